// File: rtl/tdm_serial_master.sv
// Multi-slot (TDM) serial audio master: divides pclk down to sclk,
// frames slots with ws, serialises tx words and deserialises rx words
// in I2S, left-justified, right-justified and DSP-pulse formats.
module tdm_serial_master #(
  parameter int CHANNELS = 8,
  parameter int SLOT_W   = 32,
  parameter int WORD_W   = 24,
  parameter int DIV_W    = 8
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic                        en,
  input  logic [DIV_W-1:0]            clk_div,
  input  logic [1:0]                  fmt,
  input  logic [$clog2(CHANNELS)-1:0] nslot_m1,
  input  logic [WORD_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(CHANNELS)-1:0] tx_ch,
  output logic [WORD_W-1:0]           rx_data,
  output logic                        rx_valid,
  output logic [$clog2(CHANNELS)-1:0] rx_ch,
  input  logic                        sd_i,
  output logic                        sclk_o,
  output logic                        ws_o,
  output logic                        sd_o,
  output logic                        busy,
  output logic                        underrun,
  input  logic                        clr_err
);

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int BIT_W = $clog2(SLOT_W);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] PAD       = BIT_W'(SLOT_W - WORD_W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nx;

  // Divider and framing state
  logic [DIV_W-1:0] div_cnt, div_l;
  logic [1:0]       fmt_l;
  logic [CH_W-1:0]  nslot_l;
  logic [BIT_W-1:0] bit_cnt, prev_bit;
  logic [CH_W-1:0]  slot_cnt, prev_slot;
  logic             started;

  // Transmit path
  logic [SLOT_W-1:0] shift;
  logic              last_bit;
  logic [WORD_W-1:0] hold;
  logic              hold_full;

  // Receive path
  logic [WORD_W-2:0] rx_shift;

  // Event decode
  logic tick, fall_ev, rise_ev, start_ev, slot_end, frame_end, stop, restart;
  logic load, cfg_ld, transfer;
  logic [1:0]        fmt_n;
  logic [CH_W-1:0]   nslot_n;
  logic [BIT_W-1:0]  bit_n;
  logic [CH_W-1:0]   slot_n;
  logic [SLOT_W-1:0] img;
  logic              cur_bit, ws_n;
  logic [BIT_W-1:0]  eff_bit;
  logic [CH_W-1:0]   eff_slot;
  logic              eff_ok, in_win, win_end, sample;

  // Places a word into a slot image, MSB at the top: right-justified puts
  // the zero padding first, every other format puts it after the word.
  function automatic logic [SLOT_W-1:0] slot_image(input logic [WORD_W-1:0] word,
                                                   input logic [1:0] f);
    logic [SLOT_W-1:0] r;
    r = SLOT_W'(word);
    if (f != 2'd2) r = r << (SLOT_W - WORD_W);
    return r;
  endfunction

  // Word-select level for a bit position: half-frame split for I2S/LJ/RJ,
  // a one-bit pulse on the very last bit of the frame for DSP mode.
  function automatic logic ws_level(input logic [1:0] f, input logic [CH_W-1:0] ns,
                                    input logic [CH_W-1:0] slot,
                                    input logic [BIT_W-1:0] bitpos);
    logic [CH_W:0] half;
    half = ({1'b0, ns} + {{CH_W{1'b0}}, 1'b1}) >> 1;
    if (f == 2'd3) return (slot == ns) && (bitpos == BIT_LAST);
    return {1'b0, slot} >= half;
  endfunction

  assign tick      = (state == RUN) && (div_cnt == div_l);
  assign fall_ev   = tick && sclk_o;
  assign rise_ev   = tick && !sclk_o;
  assign start_ev  = (state == IDLE) && en;
  assign slot_end  = (bit_cnt == BIT_LAST);
  assign frame_end = fall_ev && slot_end && (slot_cnt == nslot_l);
  assign stop      = frame_end && !en;
  assign restart   = frame_end && en;
  assign load      = start_ev || (fall_ev && slot_end && !stop);
  assign cfg_ld    = start_ev || restart;
  assign fmt_n     = cfg_ld ? fmt : fmt_l;
  assign nslot_n   = cfg_ld ? nslot_m1 : nslot_l;
  assign transfer  = tx_valid && !hold_full;
  assign img       = slot_image(hold_full ? hold : '0, fmt_n);
  assign cur_bit   = load ? img[SLOT_W-1] : shift[SLOT_W-1];
  assign ws_n      = ws_level(fmt_n, nslot_n, slot_n, bit_n);

  // I2S sees the data one bit late, so its window is indexed by the
  // previous bit position; the first bit after leaving IDLE has no
  // predecessor and is never sampled.
  assign eff_bit  = (fmt_l == 2'd0) ? prev_bit : bit_cnt;
  assign eff_slot = (fmt_l == 2'd0) ? prev_slot : slot_cnt;
  assign eff_ok   = (fmt_l != 2'd0) || started;
  assign in_win   = eff_ok && ((fmt_l == 2'd2) ? (eff_bit >= PAD) : (eff_bit <= WORD_LAST));
  assign win_end  = (fmt_l == 2'd2) ? (eff_bit == BIT_LAST) : (eff_bit == WORD_LAST);
  assign sample   = rise_ev && in_win;

  assign busy     = (state == RUN);
  assign tx_ready = !hold_full;

  // Next bit/slot position taken at a falling event or frame start
  always_comb begin
    bit_n  = bit_cnt + BIT_W'(1);
    slot_n = slot_cnt;
    if (start_ev) begin
      bit_n  = '0;
      slot_n = '0;
    end else if (slot_end) begin
      bit_n  = '0;
      slot_n = (slot_cnt == nslot_l) ? '0 : slot_cnt + CH_W'(1);
    end
  end

  // Run/idle next-state: a started frame always runs to its last slot
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (stop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) state <= IDLE;
    else         state <= state_nx;
  end

  // sclk divider: toggles at terminal count, parked low outside a frame
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      div_cnt <= '0;
      sclk_o  <= 1'b0;
    end else if (start_ev) begin
      div_cnt <= '0;
      sclk_o  <= 1'b0;
    end else if (state == RUN) begin
      if (tick) begin
        div_cnt <= '0;
        sclk_o  <= stop ? 1'b0 : !sclk_o;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Bit/slot counters and per-frame configuration latch
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      bit_cnt   <= '0;
      slot_cnt  <= '0;
      prev_bit  <= '0;
      prev_slot <= '0;
      started   <= 1'b0;
      fmt_l     <= '0;
      nslot_l   <= '0;
      div_l     <= '0;
    end else begin
      if (cfg_ld) begin
        fmt_l   <= fmt;
        nslot_l <= nslot_m1;
        div_l   <= clk_div;
      end
      if (start_ev) begin
        bit_cnt  <= '0;
        slot_cnt <= '0;
        started  <= 1'b0;
      end else if (fall_ev) begin
        prev_bit  <= bit_cnt;
        prev_slot <= slot_cnt;
        if (stop) begin
          bit_cnt  <= '0;
          slot_cnt <= '0;
          started  <= 1'b0;
        end else begin
          bit_cnt  <= bit_n;
          slot_cnt <= slot_n;
          started  <= 1'b1;
        end
      end
    end
  end

  // Serialiser: sd_o/ws_o change on falling events, I2S delayed by one bit
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      shift    <= '0;
      last_bit <= 1'b0;
      sd_o     <= 1'b0;
      ws_o     <= 1'b0;
    end else if (start_ev || (fall_ev && !stop)) begin
      shift    <= load ? (img << 1) : (shift << 1);
      last_bit <= cur_bit;
      sd_o     <= (fmt_n == 2'd0) ? last_bit : cur_bit;
      ws_o     <= ws_n;
    end else if (stop) begin
      shift    <= '0;
      last_bit <= 1'b0;
      sd_o     <= 1'b0;
      ws_o     <= 1'b0;
    end
  end

  // Holding register, slot tag and sticky underrun (clear beats set)
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      hold      <= '0;
      hold_full <= 1'b0;
      tx_ch     <= '0;
      underrun  <= 1'b0;
    end else begin
      if (transfer) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) tx_ch <= (tx_ch >= nslot_n) ? '0 : tx_ch + CH_W'(1);
      if (clr_err)                 underrun <= 1'b0;
      else if (load && !hold_full) underrun <= 1'b1;
    end
  end

  // Deserialiser: shift on rising events inside the window, strobe after the last sample
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      rx_shift <= '0;
      rx_data  <= '0;
      rx_ch    <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= sample && win_end;
      if (sample) rx_shift <= {rx_shift[WORD_W-3:0], sd_i};
      if (sample && win_end) begin
        rx_data <= {rx_shift, sd_i};
        rx_ch   <= eff_slot;
      end
    end
  end

endmodule

// File: tb/tb_tdm_serial_master.sv
// Directed bench for tdm_serial_master: loopback framing, justification,
// DSP pulse, underrun handling, end-of-run parking and async reset.
module tb_tdm_serial_master;
  localparam int CHANNELS = 8;
  localparam int SLOT_W   = 32;
  localparam int WORD_W   = 24;
  localparam int DIV_W    = 8;
  localparam int CH_W     = 3;

  logic              pclk, preset, en, tx_valid, tx_ready, rx_valid;
  logic              sd_i, sclk_o, ws_o, sd_o, busy, underrun, clr_err;
  logic [DIV_W-1:0]  clk_div;
  logic [1:0]        fmt;
  logic [CH_W-1:0]   nslot_m1, tx_ch, rx_ch;
  logic [WORD_W-1:0] tx_data, rx_data;
  logic              loop_en, sd_drv;

  assign sd_i = loop_en ? sd_o : sd_drv;

  tdm_serial_master #(.CHANNELS(CHANNELS), .SLOT_W(SLOT_W), .WORD_W(WORD_W), .DIV_W(DIV_W)) dut (
    .pclk(pclk), .preset(preset), .en(en), .clk_div(clk_div), .fmt(fmt),
    .nslot_m1(nslot_m1), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_ch(tx_ch), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ch(rx_ch),
    .sd_i(sd_i), .sclk_o(sclk_o), .ws_o(ws_o), .sd_o(sd_o), .busy(busy),
    .underrun(underrun), .clr_err(clr_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [WORD_W-1:0] tx_words [0:31];
  int tx_wr = 0;
  int tx_rd = 0;

  logic cap_sd [0:1023];
  logic cap_ws [0:1023];
  time  cap_t  [0:1023];
  int   cap_n = 0;
  logic sclk_prev = 1'b0;

  logic [WORD_W-1:0] rx_d [0:63];
  logic [CH_W-1:0]   rx_c [0:63];
  int   rx_n = 0;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Line monitor: one capture per sclk rising edge, one entry per rx strobe
  always @(negedge pclk) begin
    if (sclk_o && !sclk_prev && cap_n < 1024) begin
      cap_sd[cap_n] <= sd_o;
      cap_ws[cap_n] <= ws_o;
      cap_t[cap_n]  <= $time;
      cap_n         <= cap_n + 1;
    end
    sclk_prev <= sclk_o;
    if (rx_valid && rx_n < 64) begin
      rx_d[rx_n] <= rx_data;
      rx_c[rx_n] <= rx_ch;
      rx_n       <= rx_n + 1;
    end
  end

  // tx feeder: offers queued words, advances when the offer met tx_ready
  initial begin
    logic offered;
    offered  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge pclk);
      if (offered) tx_rd++;
      if (tx_rd < tx_wr) begin
        tx_valid = 1'b1;
        tx_data  = tx_words[tx_rd];
      end else begin
        tx_valid = 1'b0;
        tx_data  = '0;
      end
      offered = tx_valid && tx_ready;
    end
  end

  task automatic push(input logic [WORD_W-1:0] w);
    tx_words[tx_wr] = w;
    tx_wr++;
  endtask

  function automatic logic [31:0] get_bits(input int b, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], cap_sd[b + i]};
    return r;
  endfunction

  function automatic logic [31:0] rx_at(input int i);
    return {5'd0, rx_c[i], rx_d[i]};
  endfunction

  task automatic wait_caps(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (cap_n < target && k < budget) begin
      @(negedge pclk);
      k++;
    end
    chk(tag, 32'(k >= budget), 32'd0);
  endtask

  task automatic wait_rx(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (rx_n < target && k < budget) begin
      @(negedge pclk);
      k++;
    end
    chk(tag, 32'(k >= budget), 32'd0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge pclk);
      k++;
    end
    chk(tag, 32'(k >= budget), 32'd0);
    repeat (2) @(negedge pclk);
  endtask

  task automatic wait_sclk_hi(input int budget, input string tag);
    int k;
    k = 0;
    while (!sclk_o && k < budget) begin
      @(negedge pclk);
      k++;
    end
    chk(tag, 32'(k >= budget), 32'd0);
  endtask

  initial begin
    int base, rb, cnt;
    preset = 1'b1; en = 1'b0; clk_div = 8'd1; fmt = 2'd0; nslot_m1 = 3'd1;
    clr_err = 1'b0; loop_en = 1'b1; sd_drv = 1'b0;

    // Reset values
    #3 preset = 1'b0;
    #5;
    chk("rst_sclk", 32'(sclk_o), 32'd0);
    chk("rst_ws", 32'(ws_o), 32'd0);
    chk("rst_sd", 32'(sd_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rxv", 32'(rx_valid), 32'd0);
    chk("rst_rxd", 32'(rx_data), 32'd0);
    chk("rst_txch", 32'(tx_ch), 32'd0);
    chk("rst_und", 32'(underrun), 32'd0);
    chk("rst_rdy", 32'(tx_ready), 32'd1);
    @(negedge pclk);
    preset = 1'b1;

    // I2S, two slots, two frames, loopback
    fmt = 2'd0; nslot_m1 = 3'd1;
    push(24'hABCDEF); push(24'h123456); push(24'h654321); push(24'h0FEDCB);
    repeat (3) @(negedge pclk);
    base = cap_n; rb = rx_n;
    en = 1'b1;
    wait_caps(base + 70, 2000, "t1_caps_tmo");
    en = 1'b0;
    wait_idle(2000, "t1_idle_tmo");
    chk("t1_period", 32'(cap_t[base + 1] - cap_t[base]), 32'd40);
    chk("t1_sd_w0", get_bits(base, 25), 32'h00ABCDEF);
    chk("t1_sd_w1", get_bits(base + 33, 24), 32'h00123456);
    chk("t1_sd_w2", get_bits(base + 65, 24), 32'h00654321);
    chk("t1_ws31", 32'(cap_ws[base + 31]), 32'd0);
    chk("t1_ws32", 32'(cap_ws[base + 32]), 32'd1);
    chk("t1_ws63", 32'(cap_ws[base + 63]), 32'd1);
    chk("t1_ws64", 32'(cap_ws[base + 64]), 32'd0);
    chk("t1_nrx", 32'(rx_n - rb), 32'd4);
    chk("t1_rx0", rx_at(rb), 32'h00ABCDEF);
    chk("t1_rx1", rx_at(rb + 1), 32'h01123456);
    chk("t1_rx2", rx_at(rb + 2), 32'h00654321);
    chk("t1_rx3", rx_at(rb + 3), 32'h010FEDCB);
    chk("t1_nsclk", 32'(cap_n - base), 32'd128);
    chk("t1_park_sclk", 32'(sclk_o), 32'd0);
    chk("t1_park_ws", 32'(ws_o), 32'd0);
    chk("t1_park_sd", 32'(sd_o), 32'd0);
    chk("t1_und", 32'(underrun), 32'd0);
    chk("t1_txch", 32'(tx_ch), 32'd0);

    // Right-justified, single frame, en dropped in slot 0
    fmt = 2'd2;
    push(24'hABCDEF); push(24'h123456);
    repeat (3) @(negedge pclk);
    base = cap_n; rb = rx_n;
    en = 1'b1;
    @(negedge pclk);
    chk("t2_busy", 32'(busy), 32'd1);
    en = 1'b0;
    wait_idle(2000, "t2_idle_tmo");
    chk("t2_pad0", get_bits(base, 8), 32'd0);
    chk("t2_sd_w0", get_bits(base + 8, 24), 32'h00ABCDEF);
    chk("t2_pad1", get_bits(base + 32, 8), 32'd0);
    chk("t2_sd_w1", get_bits(base + 40, 24), 32'h00123456);
    chk("t2_ws31", 32'(cap_ws[base + 31]), 32'd0);
    chk("t2_ws32", 32'(cap_ws[base + 32]), 32'd1);
    chk("t2_nrx", 32'(rx_n - rb), 32'd2);
    chk("t2_rx0", rx_at(rb), 32'h00ABCDEF);
    chk("t2_rx1", rx_at(rb + 1), 32'h01123456);
    chk("t2_nsclk", 32'(cap_n - base), 32'd64);

    // DSP pulse, four slots
    fmt = 2'd3; nslot_m1 = 3'd3;
    push(24'h1); push(24'h2); push(24'h3); push(24'h4);
    repeat (3) @(negedge pclk);
    base = cap_n; rb = rx_n;
    en = 1'b1;
    @(negedge pclk);
    en = 1'b0;
    wait_idle(4000, "t3_idle_tmo");
    cnt = 0;
    for (int i = 0; i < 128; i++) cnt += int'(cap_ws[base + i]);
    chk("t3_ws_cnt", 32'(cnt), 32'd1);
    chk("t3_ws127", 32'(cap_ws[base + 127]), 32'd1);
    chk("t3_sd_w0", get_bits(base, 24), 32'd1);
    chk("t3_sd_w3", get_bits(base + 96, 24), 32'd4);
    chk("t3_nsclk", 32'(cap_n - base), 32'd128);
    chk("t3_nrx", 32'(rx_n - rb), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_rx", rx_at(rb + i), 32'((i << 24) | (i + 1)));
    chk("t3_und", 32'(underrun), 32'd0);

    // Underrun: only slot 0 supplied, then clear, then clear-vs-set
    fmt = 2'd1; nslot_m1 = 3'd1;
    push(24'h111111);
    repeat (3) @(negedge pclk);
    base = cap_n; rb = rx_n;
    en = 1'b1;
    @(negedge pclk);
    en = 1'b0;
    wait_idle(2000, "t4_idle_tmo");
    chk("t4_und_set", 32'(underrun), 32'd1);
    chk("t4_sd_w0", get_bits(base, 24), 32'h00111111);
    chk("t4_sd_slot1", get_bits(base + 32, 32), 32'd0);
    chk("t4_rx0", rx_at(rb), 32'h00111111);
    chk("t4_rx1", rx_at(rb + 1), 32'h01000000);
    @(negedge pclk); clr_err = 1'b1;
    @(negedge pclk); clr_err = 1'b0;
    chk("t4_und_clr", 32'(underrun), 32'd0);
    @(negedge pclk);
    en = 1'b1; clr_err = 1'b1;
    @(negedge pclk);
    chk("t4_clr_wins", 32'(underrun), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    en = 1'b0; clr_err = 1'b0;
    wait_idle(2000, "t4b_idle_tmo");
    chk("t4_und_again", 32'(underrun), 32'd1);
    chk("t4_txch", 32'(tx_ch), 32'd0);

    // Asynchronous reset in the middle of slot 1
    fmt = 2'd1; nslot_m1 = 3'd1;
    push(24'h5A5A5A); push(24'hA5A5A5); push(24'h3C3C3C);
    repeat (3) @(negedge pclk);
    rb = rx_n;
    en = 1'b1;
    wait_rx(rb + 2, 2000, "t5_rx_tmo");
    wait_sclk_hi(100, "t5_sclk_tmo");
    chk("t5_pre_busy", 32'(busy), 32'd1);
    chk("t5_pre_rdy", 32'(tx_ready), 32'd0);
    chk("t5_pre_ws", 32'(ws_o), 32'd1);
    chk("t5_pre_rxd", 32'(rx_data), 32'h00A5A5A5);
    #2 preset = 1'b0;
    #1;
    chk("t5_sclk", 32'(sclk_o), 32'd0);
    chk("t5_ws", 32'(ws_o), 32'd0);
    chk("t5_sd", 32'(sd_o), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rdy", 32'(tx_ready), 32'd1);
    chk("t5_txch", 32'(tx_ch), 32'd0);
    chk("t5_rxch", 32'(rx_ch), 32'd0);
    chk("t5_rxd", 32'(rx_data), 32'd0);
    chk("t5_rxv", 32'(rx_valid), 32'd0);
    chk("t5_und", 32'(underrun), 32'd0);
    @(negedge pclk);
    en = 1'b0;
    preset = 1'b1;
    repeat (2) @(negedge pclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
